// File: rtl/ahbl_apb_bridge_if.sv
// AHB-Lite slave side plus APB3 master side of the bridge, bundled as one bus.
// Latency: none, wires only.
// Backpressure: hreadyout stalls AHB and pready stalls APB; both are carried here.
interface ahbl_apb_bridge_if #(
  parameter int W_ADDR = 32
);
  // AHB-Lite side
  logic              hsel;
  logic [W_ADDR-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic              hready;
  logic [31:0]       hwdata;
  logic              hreadyout;
  logic              hresp;
  logic [31:0]       hrdata;

  // APB3 side
  logic [W_ADDR-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  // Bridge view: AHB slave, APB master
  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hready, hwdata,
    output hreadyout, hresp, hrdata,
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  // Environment view: AHB master and APB peripheral
  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hready, hwdata,
    input  hreadyout, hresp, hrdata,
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/ahbl_apb_bridge.sv
// AHB-Lite slave to APB3 master bridge: one AHB transfer becomes one APB transfer.
// Latency: read done 3 cycles after address phase, write 4 (pready in first ACCESS cycle).
// Backpressure: hreadyout held low until APB completes, pslverr, or ACCESS timeout.
module ahbl_apb_bridge #(
  parameter int W_ADDR  = 32,
  parameter int TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst,
  ahbl_apb_bridge_if.slave bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WDATA  = 3'd1;
  localparam logic [2:0] SETUP  = 3'd2;
  localparam logic [2:0] ACCESS = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;
  localparam logic [2:0] ERR1   = 3'd5;
  localparam logic [2:0] ERR2   = 3'd6;

  // Counter only needs to reach TIMEOUT-1; TIMEOUT=0 leaves it free-running and unused.
  localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam bit            TO_EN   = (TIMEOUT != 0);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [CW-1:0]     cnt;
  logic              accept;
  logic              abort;
  logic              rd_ok;

  logic              hreadyout_q;
  logic              hresp_q;
  logic [31:0]       hrdata_q;
  logic [W_ADDR-1:0] paddr_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [31:0]       pwdata_q;

  // A new address phase can only land while the bridge is advertising ready.
  always_comb begin
    accept = bus.hsel & bus.hready & bus.htrans[1] & hreadyout_q &
             ((state == IDLE) | (state == DONE) | (state == ERR2));
    abort  = TO_EN & ~bus.pready & (cnt == TO_LAST);
    rd_ok  = (state == ACCESS) & bus.pready & ~bus.pslverr & ~pwrite_q;
  end

  // Next-state decode; DONE and ERR2 chain directly into a new transfer when one is presented.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR2: begin
        if (accept) begin
          if (bus.hsize != 3'b010) state_nxt = ERR1;
          else if (bus.hwrite)     state_nxt = WDATA;
          else                     state_nxt = SETUP;
        end else begin
          state_nxt = IDLE;
        end
      end
      WDATA:  state_nxt = SETUP;
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        if (bus.pready)  state_nxt = bus.pslverr ? ERR1 : DONE;
        else if (abort)  state_nxt = ERR1;
      end
      ERR1:    state_nxt = ERR2;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and bus-control outputs, registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      hreadyout_q <= (state_nxt == IDLE) | (state_nxt == DONE) | (state_nxt == ERR2);
      hresp_q     <= (state_nxt == ERR1) | (state_nxt == ERR2);
      psel_q      <= (state_nxt == SETUP) | (state_nxt == ACCESS);
      penable_q   <= (state_nxt == ACCESS);
    end
  end

  // Address/direction captured at the AHB address phase and held through the APB access.
  always_ff @(posedge clk) begin
    if (rst) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
    end else if (accept) begin
      paddr_q  <= bus.haddr;
      pwrite_q <= bus.hwrite;
    end
  end

  // Write data arrives one cycle after the address, which is exactly the WDATA state.
  always_ff @(posedge clk) begin
    if (rst)                 pwdata_q <= '0;
    else if (state == WDATA) pwdata_q <= bus.hwdata;
  end

  // Read data only updates on a clean read completion; errors and writes keep the old value.
  always_ff @(posedge clk) begin
    if (rst)        hrdata_q <= '0;
    else if (rd_ok) hrdata_q <= bus.prdata;
  end

  // ACCESS-cycle counter for the pready timeout; cleared as SETUP is entered.
  always_ff @(posedge clk) begin
    if (rst)                      cnt <= '0;
    else if (state_nxt == SETUP)  cnt <= '0;
    else if (state == ACCESS)     cnt <= cnt + 1'b1;
  end

  assign bus.hreadyout = hreadyout_q;
  assign bus.hresp     = hresp_q;
  assign bus.hrdata    = hrdata_q;
  assign bus.paddr     = paddr_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;

endmodule

// File: tb/tb_ahbl_apb_bridge.sv
// Self-checking bench for ahbl_apb_bridge with TIMEOUT=4.
// Latency: response and APB completions checked by scoreboard monitors.
// Backpressure: APB slave model inserts a per-transfer number of pready-low cycles.
module tb_ahbl_apb_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ahbl_apb_bridge_if #(.W_ADDR(32)) bus();
  assign bus.hready = bus.hreadyout;

  ahbl_apb_bridge #(.W_ADDR(32), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  typedef struct {
    logic        resp;
    logic [31:0] rdata;
    int          waits;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          nacc;
  } apb_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          swait;
    logic        serr;
    logic [31:0] srdata;
    logic        e_resp;
    logic [31:0] e_rdata;
    int          e_waits;
    bit          e_apb;
    int          e_nacc;
    bit          b2b;
  } vec_t;

  rsp_t rsp_q[$];
  apb_t apb_q[$];
  bit   mon_en = 1'b0;

  // APB slave model: pready after s_wait low ACCESS cycles
  int          s_wait;
  logic        s_err;
  logic [31:0] s_rdata;
  int          s_cnt = 0;

  always @(negedge clk) begin
    if (bus.psel && bus.penable) begin
      if (s_cnt == s_wait) begin
        bus.pready  = 1'b1;
        bus.pslverr = s_err;
        bus.prdata  = s_rdata;
      end else begin
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
      end
      s_cnt++;
    end else begin
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
      bus.prdata  = 32'h0;
      s_cnt       = 0;
    end
  end

  // AHB response monitor: one event per run of wait states ending in hreadyout=1
  int   r_waits = 0;
  logic r_prev_resp = 1'b0;
  rsp_t r_exp;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!bus.hreadyout) begin
        r_waits++;
      end else if (r_waits > 0) begin
        if (rsp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: got response after %0d waits, required none", r_waits);
        end else begin
          r_exp = rsp_q.pop_front();
          check("rsp_first_cycle", 32'(r_prev_resp), 32'(r_exp.resp));
          check("rsp_final_cycle", 32'(bus.hresp), 32'(r_exp.resp));
          check("rsp_wait_states", 32'(r_waits), 32'(r_exp.waits));
          check("hrdata", bus.hrdata, r_exp.rdata);
        end
        r_waits = 0;
      end
      r_prev_resp = bus.hresp;
    end
  end

  // APB monitor: stability during ACCESS, one event per psel fall
  int          a_setup = 0;
  int          a_acc   = 0;
  logic        a_prev  = 1'b0;
  logic [31:0] a_addr;
  logic        a_wr;
  logic [31:0] a_wdata;
  apb_t        a_exp;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.psel && !bus.penable) begin
        a_setup++;
        a_addr  = bus.paddr;
        a_wr    = bus.pwrite;
        a_wdata = bus.pwdata;
      end else if (bus.psel && bus.penable) begin
        a_acc++;
        check("paddr_stable", bus.paddr, a_addr);
        check("pwrite_stable", 32'(bus.pwrite), 32'(a_wr));
        check("pwdata_stable", bus.pwdata, a_wdata);
      end else begin
        check("penable_without_psel", 32'(bus.penable), 32'h0);
        if (a_prev) begin
          if (apb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL apb_unexpected: got access to 0x%08h, required none", a_addr);
          end else begin
            a_exp = apb_q.pop_front();
            check("apb_addr", a_addr, a_exp.addr);
            check("apb_write", 32'(a_wr), 32'(a_exp.wr));
            if (a_exp.wr) check("apb_wdata", a_wdata, a_exp.wdata);
            check("apb_access_cycles", 32'(a_acc), 32'(a_exp.nacc));
            check("apb_setup_cycles", 32'(a_setup), 32'h1);
          end
          a_setup = 0;
          a_acc   = 0;
        end
      end
      a_prev = bus.psel;
    end
  end

  // Issue one AHB transfer from a posedge+1 slot where hreadyout=1; return when hreadyout=1 again
  task automatic issue(input vec_t v);
    rsp_t r;
    apb_t a;
    s_wait  = v.swait;
    s_err   = v.serr;
    s_rdata = v.srdata;
    r.resp  = v.e_resp;
    r.rdata = v.e_rdata;
    r.waits = v.e_waits;
    rsp_q.push_back(r);
    if (v.e_apb) begin
      a.addr  = v.addr;
      a.wr    = v.wr;
      a.wdata = v.wdata;
      a.nacc  = v.e_nacc;
      apb_q.push_back(a);
    end
    bus.hsel   = 1'b1;
    bus.haddr  = v.addr;
    bus.htrans = 2'b10;
    bus.hwrite = v.wr;
    bus.hsize  = v.size;
    @(posedge clk);
    #1;
    bus.hsel   = 1'b0;
    bus.htrans = 2'b00;
    bus.hwdata = v.wdata;
    for (int i = 0; i < 50 && !bus.hreadyout; i++) begin
      @(posedge clk);
      #1;
    end
    check("xfer_completes", 32'(bus.hreadyout), 32'h1);
  endtask

  vec_t vecs[8];
  vec_t rv;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            addr           wr    size    wdata          swait serr  srdata         resp  e_rdata        waits apb   nacc b2b
    vecs[0] = '{32'h2600_0004, 1'b0, 3'b010, 32'h0000_0000,   0, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 2, 1'b1, 1, 1'b0};
    vecs[1] = '{32'h2600_0010, 1'b1, 3'b010, 32'hA5A5_0001,   3, 1'b0, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 6, 1'b1, 4, 1'b0};
    vecs[2] = '{32'h2600_0008, 1'b0, 3'b010, 32'h0000_0000,   0, 1'b1, 32'h0000_1234, 1'b1, 32'hDEAD_BEEF, 3, 1'b1, 1, 1'b0};
    vecs[3] = '{32'h2600_000C, 1'b0, 3'b010, 32'h0000_0000, 100, 1'b0, 32'h0000_5678, 1'b1, 32'hDEAD_BEEF, 6, 1'b1, 4, 1'b0};
    vecs[4] = '{32'h2600_0014, 1'b0, 3'b010, 32'h0000_0000,   0, 1'b0, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 2, 1'b1, 1, 1'b0};
    vecs[5] = '{32'h2600_0018, 1'b0, 3'b000, 32'h0000_0000,   0, 1'b0, 32'h7777_7777, 1'b1, 32'h0BAD_F00D, 1, 1'b0, 0, 1'b0};
    vecs[6] = '{32'h2600_001C, 1'b0, 3'b010, 32'h0000_0000,   0, 1'b0, 32'h1111_2222, 1'b0, 32'h1111_2222, 2, 1'b1, 1, 1'b1};
    vecs[7] = '{32'h2600_0020, 1'b1, 3'b010, 32'h5555_AAAA,   1, 1'b0, 32'h0000_0000, 1'b0, 32'h1111_2222, 4, 1'b1, 2, 1'b0};

    rst        = 1'b1;
    bus.hsel   = 1'b0;
    bus.haddr  = 32'h0;
    bus.htrans = 2'b00;
    bus.hwrite = 1'b0;
    bus.hsize  = 3'b010;
    bus.hwdata = 32'h0;
    s_wait     = 0;
    s_err      = 1'b0;
    s_rdata    = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hreadyout", 32'(bus.hreadyout), 32'h1);
    check("reset_hresp", 32'(bus.hresp), 32'h0);
    check("reset_hrdata", bus.hrdata, 32'h0);
    check("reset_paddr", bus.paddr, 32'h0);
    check("reset_psel", 32'(bus.psel), 32'h0);
    check("reset_penable", 32'(bus.penable), 32'h0);
    check("reset_pwrite", 32'(bus.pwrite), 32'h0);
    check("reset_pwdata", bus.pwdata, 32'h0);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      issue(vecs[i]);
      if (!vecs[i].b2b) begin
        @(posedge clk);
        #1;
      end
    end

    // Reset during ACCESS: transfer dropped, outputs forced to reset values
    rv = '{32'h2600_0024, 1'b0, 3'b010, 32'h0, 100, 1'b0, 32'h9999_9999, 1'b0, 32'h0, 2, 1'b1, 1, 1'b0};
    s_wait  = rv.swait;
    s_err   = rv.serr;
    s_rdata = rv.srdata;
    rsp_q.push_back('{rv.e_resp, rv.e_rdata, rv.e_waits});
    apb_q.push_back('{rv.addr, rv.wr, rv.wdata, rv.e_nacc});
    bus.hsel   = 1'b1;
    bus.haddr  = rv.addr;
    bus.htrans = 2'b10;
    bus.hwrite = 1'b0;
    bus.hsize  = 3'b010;
    @(posedge clk);
    #1;
    bus.hsel   = 1'b0;
    bus.htrans = 2'b00;
    @(posedge clk);
    #1;
    check("pre_reset_psel", 32'(bus.psel), 32'h1);
    check("pre_reset_penable", 32'(bus.penable), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_psel", 32'(bus.psel), 32'h0);
    check("midreset_penable", 32'(bus.penable), 32'h0);
    check("midreset_hreadyout", 32'(bus.hreadyout), 32'h1);
    check("midreset_hresp", 32'(bus.hresp), 32'h0);
    rst = 1'b0;

    // IDLE and BUSY with hsel=1: no APB activity, OKAY
    bus.hsel  = 1'b1;
    bus.haddr = 32'h2600_0030;
    for (int i = 0; i < 6; i++) begin
      bus.htrans = (i < 3) ? 2'b00 : 2'b01;
      @(posedge clk);
      #1;
      check("idle_psel", 32'(bus.psel), 32'h0);
      check("idle_hreadyout", 32'(bus.hreadyout), 32'h1);
      check("idle_hresp", 32'(bus.hresp), 32'h0);
    end
    bus.hsel   = 1'b0;
    bus.htrans = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rsp_queue_drained", 32'(rsp_q.size()), 32'h0);
    check("apb_queue_drained", 32'(apb_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
